sdram_pattern_checker: RTL and testbench

SDRAM_PATTERN_CHECKER -- requirements
Module: sdram_pattern_checker

---
 rtl/sdram_pattern_checker_pkg.sv | 28 ++
 rtl/sdram_pattern_checker_if.sv | 29 ++
 rtl/sdram_pattern_gen.sv | 40 ++++
 rtl/sdram_pattern_checker.sv | 169 ++++++++++++++++
 tb/tb_sdram_pattern_checker.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pattern_checker_pkg.sv
`default_nettype none
// ============================================================================
// Package   : sdram_test_pkg
// Purpose   : FSM state codes, pattern mode codes and fill byte for the checker
// Revision  : 1.0
// ============================================================================
package sdram_test_pkg;

  localparam int IDX_W = 20;
  localparam int ERR_W = 16;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WRITE = 3'd1;
  localparam state_t ST_READ  = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  typedef logic [1:0] mode_t;
  localparam mode_t MODE_BYTE_RAMP = 2'd0;
  localparam mode_t MODE_WALK_ONE  = 2'd1;
  localparam mode_t MODE_INV_INDEX = 2'd2;
  localparam mode_t MODE_CONST     = 2'd3;

  localparam logic [7:0] CONST_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/sdram_pattern_checker_if.sv
`default_nettype none
// ============================================================================
// Interface : sdram_pattern_checker_if
// Purpose   : Avalon-style request/read-return bus between checker and memory
// Revision  : 1.0
// ============================================================================
interface sdram_pattern_checker_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic              iWAIT_REQUEST;
  logic              iRD_VALID;
  logic [DATA_W-1:0] iRD_DATA;
  logic              oWR_EN;
  logic              oRD_EN;
  logic [ADDR_W-1:0] oADDR;
  logic [DATA_W-1:0] oWR_DATA;

  modport master (
    input  iWAIT_REQUEST, iRD_VALID, iRD_DATA,
    output oWR_EN, oRD_EN, oADDR, oWR_DATA
  );

  modport slave (
    output iWAIT_REQUEST, iRD_VALID, iRD_DATA,
    input  oWR_EN, oRD_EN, oADDR, oWR_DATA
  );
endinterface
`default_nettype wire

// File: rtl/sdram_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module    : sdram_pattern_gen
// Purpose   : Combinational test-pattern word for a given mode and word index
// Revision  : 1.0
// ============================================================================
module sdram_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  wire [1:0]       mode,
  input  wire [IDX_W-1:0] index,
  output logic [DATA_W-1:0] data
);
  localparam int NBYTES = DATA_W / 8;

  logic [7:0]       lane_base;
  logic [IDX_W-1:0] walk_pos;
  logic [IDX_W-1:0] inv_index;

  assign lane_base = 8'(index * NBYTES);
  assign walk_pos  = index % IDX_W'(DATA_W);
  assign inv_index = ~index;

  always_comb begin
    data = '0;
    case (mode)
      // Byte lane 0 sits in the most significant byte.
      MODE_BYTE_RAMP:
        for (int b = 0; b < NBYTES; b++)
          data[DATA_W-1-8*b -: 8] = (lane_base + 8'(b)) ^ 8'h80;
      MODE_WALK_ONE:  data = {{(DATA_W-1){1'b0}}, 1'b1} << walk_pos;
      MODE_INV_INDEX: data = DATA_W'(inv_index);
      MODE_CONST:     data = {NBYTES{CONST_BYTE}};
      default:        data = '0;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/sdram_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module    : sdram_pattern_checker
// Purpose   : Writes a pattern pass to SDRAM, reads it back pipelined, counts mismatches
// Revision  : 1.0
// ============================================================================
module sdram_pattern_checker
  import sdram_test_pkg::*;
#(
  parameter int              ADDR_W          = 25,
  parameter int              DATA_W          = 16,
  parameter int              N_WORDS         = 400,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter int              MAX_OUTSTANDING = 8
) (
  input  wire                     iCLK,
  input  wire                     iRST,
  input  wire                     iSTART,
  input  wire [1:0]               iMODE,
  sdram_pattern_checker_if.master bus,
  output logic                    oBUSY,
  output logic                    oDONE,
  output logic                    oPASS,
  output logic [ERR_W-1:0]        oERR_CNT,
  output logic [ADDR_W-1:0]       oFIRST_ERR_ADDR
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [3:0]       MAX_OUT  = 4'(MAX_OUTSTANDING);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   k_q, k_d, j_q, j_d, m_q, m_d;
  logic [3:0]         out_q, out_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]  first_err_q, first_err_d;
  mode_t              mode_q, mode_d;

  logic               start_ok, req_rd, wr_acc, rd_acc, beat, mismatch;
  logic [IDX_W-1:0]   req_idx;
  logic [DATA_W-1:0]  req_pat, cmp_pat;
  logic               wr_en, rd_en;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  wr_data;

  assign start_ok = iSTART && (state_q == ST_IDLE || state_q == ST_DONE);
  assign req_rd   = (state_q == ST_READ) && (out_q < MAX_OUT);
  assign wr_acc   = (state_q == ST_WRITE) && !bus.iWAIT_REQUEST;
  assign rd_acc   = req_rd && !bus.iWAIT_REQUEST;
  // Beats arriving outside READ/DRAIN belong to an aborted pass.
  assign beat     = bus.iRD_VALID && (state_q == ST_READ || state_q == ST_DRAIN);
  assign mismatch = beat && (bus.iRD_DATA != cmp_pat);
  assign req_idx  = (state_q == ST_READ) ? j_q : k_q;

  sdram_pattern_gen #(.DATA_W(DATA_W)) u_req_gen (
    .mode(mode_q), .index(req_idx), .data(req_pat)
  );
  sdram_pattern_gen #(.DATA_W(DATA_W)) u_cmp_gen (
    .mode(mode_q), .index(m_q), .data(cmp_pat)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_ok) state_d = ST_WRITE;
      ST_WRITE:         if (wr_acc && k_q == LAST_IDX) state_d = ST_READ;
      ST_READ:          if (rd_acc && j_q == LAST_IDX) state_d = ST_DRAIN;
      ST_DRAIN:         if (beat && m_q == LAST_IDX) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low combinationally while reset is held.
  always_comb begin
    wr_en           = 1'b0;
    rd_en           = 1'b0;
    addr            = '0;
    wr_data         = '0;
    oBUSY           = 1'b0;
    oDONE           = 1'b0;
    oPASS           = 1'b0;
    oERR_CNT        = '0;
    oFIRST_ERR_ADDR = '0;
    if (!iRST) begin
      oERR_CNT        = err_cnt_q;
      oFIRST_ERR_ADDR = first_err_q;
      case (state_q)
        ST_WRITE: begin
          wr_en   = 1'b1;
          addr    = BASE_ADDR + ADDR_W'(k_q);
          wr_data = req_pat;
          oBUSY   = 1'b1;
        end
        ST_READ: begin
          rd_en = req_rd;
          addr  = BASE_ADDR + ADDR_W'(j_q);
          oBUSY = 1'b1;
        end
        ST_DRAIN: oBUSY = 1'b1;
        ST_DONE: begin
          oDONE = 1'b1;
          oPASS = (err_cnt_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.oWR_EN   = wr_en;
  assign bus.oRD_EN   = rd_en;
  assign bus.oADDR    = addr;
  assign bus.oWR_DATA = wr_data;

  always_comb begin
    k_d         = k_q;
    j_d         = j_q;
    m_d         = m_q;
    out_d       = out_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    mode_d      = mode_q;
    if (start_ok) begin
      k_d         = '0;
      j_d         = '0;
      m_d         = '0;
      out_d       = '0;
      err_cnt_d   = '0;
      first_err_d = '0;
      mode_d      = iMODE;
    end else begin
      if (wr_acc) k_d = k_q + IDX_W'(1);
      if (rd_acc) j_d = j_q + IDX_W'(1);
      if (beat)   m_d = m_q + IDX_W'(1);
      case ({rd_acc, beat})
        2'b10:   out_d = out_q + 4'd1;
        2'b01:   out_d = out_q - 4'd1;
        default: out_d = out_q;
      endcase
      if (mismatch) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
        if (err_cnt_q == '0) first_err_d = BASE_ADDR + ADDR_W'(m_q);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      k_q         <= '0;
      j_q         <= '0;
      m_q         <= '0;
      out_q       <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      mode_q      <= MODE_BYTE_RAMP;
    end else begin
      k_q         <= k_d;
      j_q         <= j_d;
      m_q         <= m_d;
      out_q       <= out_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      mode_q      <= mode_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sdram_pattern_checker.sv
`default_nettype none
// Bench for sdram_pattern_checker: behavioural memory with configurable stall/latency,
// pattern reference computed from the byte/bit rules, directed pass sequence.
module tb_sdram_pattern_checker;
  localparam int          ADDR_W  = 25;
  localparam int          DATA_W  = 16;
  localparam int          N_WORDS = 400;
  localparam int          MAX_OUT = 4;
  localparam logic [24:0] BASE    = 25'h1FF_FF00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [1:0]  mode;
  logic        busy, done, pass;
  logic [15:0] err_cnt;
  logic [24:0] first_err;

  sdram_pattern_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_pattern_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_WORDS(N_WORDS),
    .BASE_ADDR(BASE), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .iCLK(clk), .iRST(rst), .iSTART(start), .iMODE(mode), .bus(bus),
    .oBUSY(busy), .oDONE(done), .oPASS(pass),
    .oERR_CNT(err_cnt), .oFIRST_ERR_ADDR(first_err)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
    bit          stray;
  } rd_t;

  rd_t         pend[$];
  logic [15:0] mem [logic [24:0]];
  int checks = 0, errors = 0, cyc = 0;
  int wr_k, rd_j, beats, reqs, model_out, max_out, last_beat_cyc, wait_pct, lat, pass_mode;
  bit corrupt;
  bit prev_wr_stall = 0, prev_rd_stall = 0;
  logic [24:0] prev_addr;
  logic [15:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int md, input int k);
    logic [7:0]  hi, lo;
    logic [15:0] kk;
    kk = 16'(k);
    case (md)
      0: begin
        hi = 8'((2 * k) % 256) ^ 8'h80;
        lo = 8'((2 * k + 1) % 256) ^ 8'h80;
        return {hi, lo};
      end
      1:       return 16'd1 << (k % 16);
      2:       return ~kk;
      default: return 16'hA5A5;
    endcase
  endfunction

  task automatic mem_step();
    rd_t         e;
    logic [24:0] a;
    bus.iRD_VALID = 1'b0;
    bus.iRD_DATA  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      e = pend.pop_front();
      bus.iRD_VALID = 1'b1;
      bus.iRD_DATA  = e.stray ? ~e.data : e.data;
      if (!e.stray) begin
        model_out--;
        beats++;
        if (beats == N_WORDS) last_beat_cyc = cyc;
      end
    end
    bus.iWAIT_REQUEST = ($urandom_range(99) < wait_pct);
    chk("wr_rd_exclusive", bus.oWR_EN & bus.oRD_EN, 0);
    if (prev_wr_stall) begin
      chk("stall_wr_en", bus.oWR_EN, 1);
      chk("stall_wr_addr", bus.oADDR, prev_addr);
      chk("stall_wr_data", bus.oWR_DATA, prev_data);
    end
    if (prev_rd_stall) begin
      chk("stall_rd_en", bus.oRD_EN, 1);
      chk("stall_rd_addr", bus.oADDR, prev_addr);
    end
    prev_wr_stall = bus.oWR_EN && bus.iWAIT_REQUEST;
    prev_rd_stall = bus.oRD_EN && bus.iWAIT_REQUEST;
    prev_addr     = bus.oADDR;
    prev_data     = bus.oWR_DATA;
    if (bus.oWR_EN && !bus.iWAIT_REQUEST) begin
      a = BASE + 25'(wr_k);
      chk("wr_addr", bus.oADDR, a);
      chk("wr_data", bus.oWR_DATA, pat(pass_mode, wr_k));
      mem[bus.oADDR] = bus.oWR_DATA;
      wr_k++;
      reqs++;
    end
    if (bus.oRD_EN && !bus.iWAIT_REQUEST) begin
      a = BASE + 25'(rd_j);
      chk("rd_addr", bus.oADDR, a);
      e.due   = cyc + lat;
      e.stray = 1'b0;
      e.data  = mem.exists(bus.oADDR) ? mem[bus.oADDR] : 16'hDEAD;
      if (corrupt && (rd_j == 5 || rd_j == 9)) e.data = e.data ^ 16'h0101;
      pend.push_back(e);
      model_out++;
      rd_j++;
      reqs++;
      if (model_out > max_out) max_out = model_out;
      chk("outstanding_limit", model_out <= MAX_OUT, 1);
    end
  endtask

  task automatic step(input bit r, input bit s, input logic [1:0] md);
    @(negedge clk);
    rst   = r;
    start = s;
    mode  = md;
    #1;
    cyc++;
    mem_step();
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_wr_en"}, bus.oWR_EN, 0);
    chk({tag, "_rd_en"}, bus.oRD_EN, 0);
    chk({tag, "_addr"}, bus.oADDR, 0);
    chk({tag, "_wr_data"}, bus.oWR_DATA, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_first_err"}, first_err, 0);
  endtask

  task automatic run_pass(input logic [1:0] md, input int wp, input int lt, input bit cor, input bit poke);
    int n;
    wait_pct = wp; lat = lt; corrupt = cor; pass_mode = int'(md);
    wr_k = 0; rd_j = 0; beats = 0; reqs = 0; max_out = 0; model_out = 0; last_beat_cyc = -10;
    step(0, 1, md);
    step(0, 0, 2'($urandom));
    chk("start_busy", busy, 1);
    chk("start_done_low", done, 0);
    chk("start_err_clear", err_cnt, 0);
    chk("start_first_clear", first_err, 0);
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      step(0, poke && n == 5, (poke && n == 5) ? (md ^ 2'd1) : 2'($urandom));
      n++;
    end
    chk("done_seen", done, 1);
    chk("done_timing", cyc, last_beat_cyc + 1);
    chk("req_count", reqs, 2 * N_WORDS);
    chk("beat_count", beats, N_WORDS);
    chk("drained", model_out, 0);
    chk("done_not_busy", busy, 0);
  endtask

  initial begin
    int n;
    logic [24:0] a;
    rst = 1'b1; start = 1'b0; mode = 2'd0;
    bus.iWAIT_REQUEST = 1'b0; bus.iRD_VALID = 1'b0; bus.iRD_DATA = '0;
    wait_pct = 0; lat = 2; corrupt = 0; pass_mode = 0;
    wr_k = 0; rd_j = 0; beats = 0; reqs = 0; model_out = 0; max_out = 0; last_beat_cyc = 0;

    step(1, 0, 0);
    step(1, 0, 0);
    outputs_zero("rst_hold");
    step(0, 0, 0);
    outputs_zero("rst_idle");

    // Byte-ramp pass, no stalls, 2-cycle read latency.
    run_pass(2'd0, 0, 2, 0, 0);
    a = BASE;
    chk("t1_word0", mem[a], 16'h8081);
    a = BASE + 25'd1;
    chk("t1_word1", mem[a], 16'h8283);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_cnt, 0);
    chk("t1_first_err", first_err, 0);

    // Walking one with 30% waitrequest.
    run_pass(2'd1, 30, 2, 0, 0);
    chk("t2_pass", pass, 1);
    chk("t2_err", err_cnt, 0);

    // Inverted index with words 5 and 9 corrupted on readback.
    run_pass(2'd2, 0, 3, 1, 0);
    chk("t3_err", err_cnt, 2);
    chk("t3_first_err", first_err, BASE + 25'd5);
    chk("t3_pass", pass, 0);
    chk("t3_done", done, 1);

    // Restart from a failing DONE; a start pulse during WRITE is ignored.
    run_pass(2'd3, 20, 2, 0, 1);
    chk("t6_pass", pass, 1);
    chk("t6_err", err_cnt, 0);
    chk("t6_first_err", first_err, 0);

    // Long read latency against a 4-deep pipeline.
    run_pass(2'd0, 0, 20, 0, 0);
    chk("t4_pass", pass, 1);
    chk("t4_max_outstanding", max_out, MAX_OUT);

    // Reset in the middle of READ with three reads in flight.
    wait_pct = 0; lat = 20; corrupt = 0; pass_mode = 0;
    wr_k = 0; rd_j = 0; beats = 0; reqs = 0; model_out = 0; max_out = 0;
    step(0, 1, 2'd0);
    n = 0;
    while (!(rd_j > 0 && model_out == 3) && n < 5000) begin
      step(0, 0, 2'd0);
      n++;
    end
    chk("t5_three_outstanding", model_out, 3);
    step(1, 0, 2'd0);
    outputs_zero("t5_in_rst");
    foreach (pend[i]) pend[i].stray = 1'b1;
    model_out = 0;
    step(0, 0, 2'd0);
    outputs_zero("t5_after_rst");
    n = 0;
    while (pend.size() > 0 && n < 100) begin
      step(0, 0, 2'd0);
      n++;
    end
    chk("t5_strays_flushed", pend.size(), 0);
    chk("t5_err_cnt", err_cnt, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);

    // Recovery pass after the abort.
    run_pass(2'd1, 10, 2, 0, 0);
    chk("t7_pass", pass, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
